// File: rtl/cail_apply_if.sv
// Request/response and parameter-RAM read bus of the calibration apply block.
// The measurement-type field is named mtype because "type" is a reserved word.
`default_nettype none

interface cail_apply_if;
   logic        param_ready;
   logic        start;
   logic [3:0]  ch;
   logic [1:0]  mtype;
   logic [15:0] raw;
   logic [9:0]  ram_addr;
   logic [7:0]  ram_q;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] cal;

   modport master (
      output param_ready, start, ch, mtype, raw, ram_q,
      input  ram_addr, busy, done, err, cal
   );

   modport slave (
      input  param_ready, start, ch, mtype, raw, ram_q,
      output ram_addr, busy, done, err, cal
   );
endinterface

`default_nettype wire

// File: rtl/cail_apply.sv
// Applies a per-channel/type offset and fixed-point gain, fetched from parameter RAM,
// to one raw sample with clamping to zero and saturation at 16 bits.
`default_nettype none

module cail_apply #(
   parameter int GAIN_FRAC = 14,
   parameter int BASE_ADDR = 0
) (
   input  wire         clk,
   input  wire         rst_n,
   cail_apply_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      CALC  = 2'd2,
      SAT   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [1:0]  cnt;
   logic [15:0] raw_q;
   logic [7:0]  offset;
   logic [7:0]  gain_hi;
   logic [7:0]  gain_lo;
   logic [32:0] product;
   logic [9:0]  ram_addr;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] cal;

   logic [9:0]  entry;
   logic [17:0] sum_s;
   logic [16:0] sum_c;
   logic [32:0] shifted;

   // Three bytes per entry; the 6-bit index is {ch, type}.
   assign entry = 10'(BASE_ADDR) + ({4'd0, bus.ch, bus.mtype} * 10'd3);

   assign sum_s   = {2'b00, raw_q} + {{10{offset[7]}}, offset};
   assign sum_c   = sum_s[17] ? 17'd0 : sum_s[16:0];
   assign shifted = product >> GAIN_FRAC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start && bus.param_ready) state_next = FETCH;
         FETCH:   if (cnt == 2'd3) state_next = CALC;
         CALC:    state_next = SAT;
         SAT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 2'd0;
         raw_q    <= 16'd0;
         offset   <= 8'd0;
         gain_hi  <= 8'd0;
         gain_lo  <= 8'd0;
         product  <= 33'd0;
         ram_addr <= 10'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cal      <= 16'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= 2'd0;
               if (bus.start) begin
                  if (bus.param_ready) begin
                     raw_q    <= bus.raw;
                     ram_addr <= entry;
                     busy     <= 1'b1;
                  end else begin
                     done <= 1'b1;
                     err  <= 1'b1;
                     cal  <= 16'd0;
                  end
               end
            end
            FETCH: begin
               // Read data trails the address by one cycle, so capture starts at cnt==1.
               cnt <= cnt + 2'd1;
               if (cnt < 2'd2) ram_addr <= ram_addr + 10'd1;
               case (cnt)
                  2'd1:    offset  <= bus.ram_q;
                  2'd2:    gain_hi <= bus.ram_q;
                  2'd3:    gain_lo <= bus.ram_q;
                  default: ;
               endcase
            end
            CALC: product <= {16'd0, sum_c} * {17'd0, gain_hi, gain_lo};
            SAT: begin
               cal  <= (|shifted[32:16]) ? 16'hFFFF : shifted[15:0];
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ram_addr = ram_addr;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err;
   assign bus.cal      = cal;

endmodule

`default_nettype wire

// File: tb/tb_cail_apply.sv
// Directed self-checking bench for cail_apply with a registered-read parameter RAM model.
`default_nettype none

module tb_cail_apply;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [7:0] mem [0:1023];

   cail_apply_if bus ();

   cail_apply #(.GAIN_FRAC(14), .BASE_ADDR(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int addr, input logic [7:0] off, input logic [15:0] gain);
      mem[addr]     = off;
      mem[addr + 1] = gain[15:8];
      mem[addr + 2] = gain[7:0];
   endtask

   // Issue one request, check address sequence, latency, result and one-cycle done.
   task automatic req(input string tag, input logic [3:0] c, input logic [1:0] t,
                      input logic [15:0] r, input logic [9:0] base, input logic [15:0] exp_cal);
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.ch = c; bus.mtype = t; bus.raw = r;
      @(posedge clk); #1;
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_addr0"}, {22'd0, bus.ram_addr}, {22'd0, base});
      @(negedge clk);
      bus.start = 1'b0; bus.raw = ~r; bus.ch = ~c;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (n == 1) chk({tag, "_addr1"}, {22'd0, bus.ram_addr}, {22'd0, base + 10'd1});
         if (n == 2) chk({tag, "_addr2"}, {22'd0, bus.ram_addr}, {22'd0, base + 10'd2});
         if (bus.done) begin lat = n; break; end
      end
      chk({tag, "_latency"}, lat, 6);
      chk({tag, "_cal"}, {16'd0, bus.cal}, {16'd0, exp_cal});
      chk({tag, "_err_busy"}, {30'd0, bus.err, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      int dones;
      logic [15:0] got;
      logic [9:0]  addr_before;
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      put(0,   8'h00, 16'h4000);   // unity
      put(27,  8'hFB, 16'h8000);   // ch2 type1: -5, x2
      put(12,  8'hF6, 16'h4000);   // ch1 type0: -10
      put(42,  8'h7F, 16'hFFFF);   // ch3 type2: saturate
      put(189, 8'h00, 16'h2000);   // ch15 type3: x0.5
      put(9,   8'h0A, 16'h4000);   // ch0 type3: +10

      bus.param_ready = 1'b1; bus.start = 1'b0;
      bus.ch = 4'd0; bus.mtype = 2'd0; bus.raw = 16'd0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {bus.busy, bus.done, bus.err, bus.cal, bus.ram_addr}, 32'd0);
      rst_n = 1'b1;

      req("unity",  4'd0,  2'd0, 16'd1000,  10'd0,   16'd1000);
      req("gainoff", 4'd2, 2'd1, 16'd100,   10'd27,  16'd190);
      req("clamp",  4'd1,  2'd0, 16'd3,     10'd12,  16'd0);
      req("sat",    4'd3,  2'd2, 16'hFFFF,  10'd42,  16'hFFFF);
      req("addr15", 4'd15, 2'd3, 16'd500,   10'd189, 16'd250);
      req("plus10", 4'd0,  2'd3, 16'd90,    10'd9,   16'd100);

      // Table not loaded: immediate error completion, no RAM access.
      addr_before = bus.ram_addr;
      @(negedge clk);
      bus.param_ready = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      chk("nr_done_err", {30'd0, bus.done, bus.err}, 32'd3);
      chk("nr_cal", {16'd0, bus.cal}, 32'd0);
      chk("nr_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      bus.start = 1'b0; bus.param_ready = 1'b1;
      @(posedge clk); #1;
      chk("nr_done_pulse", {31'd0, bus.done}, 32'd0);
      chk("nr_no_read", {22'd0, bus.ram_addr}, {22'd0, addr_before});

      // Second start while busy is ignored; first request's inputs are used.
      @(negedge clk);
      bus.start = 1'b1; bus.ch = 4'd0; bus.mtype = 2'd0; bus.raw = 16'd1000;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.ch = 4'd2; bus.mtype = 2'd1; bus.raw = 16'd100;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0; got = 16'h0;
      for (int n = 0; n < 14; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin dones++; got = bus.cal; end
      end
      chk("busy_one_done", dones, 1);
      chk("busy_first_cal", {16'd0, got}, 32'd1000);

      // Reset during FETCH aborts without a done pulse.
      @(negedge clk);
      bus.start = 1'b1; bus.ch = 4'd3; bus.mtype = 2'd2; bus.raw = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {bus.busy, bus.done, bus.err, bus.cal, bus.ram_addr}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      chk("rst_no_done", dones, 0);
      req("after_rst", 4'd2, 2'd1, 16'd100, 10'd27, 16'd190);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
